booth_job_sequencer: RTL and testbench

Upstream issue stage for the radix-2 Booth multiplier core. It accepts signed operand pairs on a valid/ready input channel and pulses the core's `start`. It holds the operands stable for the core's load states, waits for `done`, and captures the 2·WIDTH-bit product. The product is then presented on a valid/ready output channel. One job is in flight at a time.

---
 rtl/booth_pkg.sv | 15 +
 rtl/booth_job_sequencer_if.sv | 31 +++
 rtl/booth_seq_timer.sv | 29 ++
 rtl/booth_job_sequencer.sv | 112 +++++++++++
 tb/tb_booth_job_sequencer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiplier issue stage.
package booth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BLANK,
    WAIT,
    RESP
  } seq_state_t;

  localparam int BLANK_CYCLES  = 2;
  localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/booth_job_sequencer_if.sv
// Operand, core and result channels of booth_job_sequencer.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface booth_job_sequencer_if import booth_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_m;
  logic [WIDTH-1:0]     in_q;
  logic                 core_start;
  logic [WIDTH-1:0]     core_m;
  logic [WIDTH-1:0]     core_q;
  logic                 core_done;
  logic [2*WIDTH-1:0]   core_product;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_product;
  logic                 out_err;

  modport slave (
    input  in_valid, in_m, in_q, core_done, core_product, out_ready,
    output in_ready, core_start, core_m, core_q, out_valid, out_product, out_err
  );

  modport master (
    output in_valid, in_m, in_q, core_done, core_product, out_ready,
    input  in_ready, core_start, core_m, core_q, out_valid, out_product, out_err
  );

endinterface

// File: rtl/booth_seq_timer.sv
// WAIT-state timeout counter: expired flags the last permitted cycle without
// core_done, so the abort lands exactly TIMEOUT cycles after WAIT entry.
module booth_seq_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/booth_job_sequencer.sv
// Issue stage for the radix-2 Booth core: one job in flight, start pulse,
// stale-done blanking and result hold. BOOTH_SEQ_TIMEOUT_EN adds a WAIT abort.
module booth_job_sequencer import booth_pkg::*; #(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  booth_job_sequencer_if.slave   bus,
  output logic                   busy
);

  seq_state_t          state, next_state;
  logic [1:0]          blank_cnt;
  logic [WIDTH-1:0]    m_q, q_q;
  logic [2*WIDTH-1:0]  product_q;
  logic                accept, capture, timed_out;

  assign accept  = (state == IDLE) && bus.in_valid;
  assign capture = (state == WAIT) && bus.core_done;

`ifdef BOOTH_SEQ_TIMEOUT_EN
  logic timer_expired;
  logic err_q;

  booth_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state != WAIT),
    .enable  ((state == WAIT) && !bus.core_done),
    .expired (timer_expired)
  );

  assign timed_out = timer_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (capture) begin
      err_q <= 1'b0;
    end else if (timed_out) begin
      err_q <= 1'b1;
    end
  end

  assign bus.out_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timed_out      = 1'b0;
  assign bus.out_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // core_done is ignored through BLANK because it may still be high from the previous job.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (bus.in_valid) next_state = START;
      START: next_state = BLANK;
      BLANK: if (blank_cnt == 2'(BLANK_CYCLES - 1)) next_state = WAIT;
      WAIT:  if (bus.core_done || timed_out) next_state = RESP;
      RESP:  if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_cnt <= '0;
    end else if (state == START) begin
      blank_cnt <= '0;
    end else if (state == BLANK) begin
      blank_cnt <= blank_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q       <= '0;
      q_q       <= '0;
      product_q <= '0;
    end else begin
      if (accept) begin
        m_q <= bus.in_m;
        q_q <= bus.in_q;
      end
      if (capture) begin
        product_q <= bus.core_product;
      end else if (timed_out) begin
        product_q <= '0;
      end
    end
  end

  // in_ready is held low while reset is asserted, not just by the IDLE decode.
  assign bus.in_ready    = rst_n && (state == IDLE);
  assign bus.core_start  = (state == START);
  assign bus.out_valid   = (state == RESP);
  assign bus.core_m      = m_q;
  assign bus.core_q      = q_q;
  assign bus.out_product = product_q;
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_booth_job_sequencer.sv
// Scoreboard bench for booth_job_sequencer with a behavioural Booth core model.
// Covers BOOTH_SEQ_TIMEOUT_EN builds as well as the default build.
module tb_booth_job_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  booth_job_sequencer_if #(.WIDTH(16)) bus ();

  booth_job_sequencer #(.WIDTH(16), .TIMEOUT(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_accept = 0;
  logic [32:0] sb[$];

  // Core model knobs, set from the stimulus process.
  int core_lat   = 40;
  bit core_hang  = 1'b0;
  bit stale_mode = 1'b0;

  logic        core_done_r = 1'b0;
  logic [31:0] core_prod_r = 32'h0;
  bit          core_running = 1'b0;
  int          core_cnt = 0;
  int          clr_pending = 0;

  assign bus.core_done    = core_done_r;
  assign bus.core_product = core_prod_r;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural core: done is sticky until the next start; stale_mode delays its
  // clearing through both blanking cycles to expose any early capture.
  always @(posedge clk) begin
    if (bus.core_start) begin
      core_running <= 1'b1;
      core_cnt     <= 0;
      if (stale_mode) clr_pending <= 2;
      else            core_done_r <= 1'b0;
    end else begin
      if (clr_pending != 0) begin
        clr_pending <= clr_pending - 1;
        if (clr_pending == 1) core_done_r <= 1'b0;
      end
      if (core_running && !core_hang) begin
        if (core_cnt == core_lat - 1) begin
          core_done_r  <= 1'b1;
          core_prod_r  <= 32'(int'($signed(bus.core_m)) * int'($signed(bus.core_q)));
          core_running <= 1'b0;
        end else begin
          core_cnt <= core_cnt + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic boundFail(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: wait bound expired, got no event, expected event", name);
  endtask

  // Scoreboard monitor: every accepted result is popped and compared.
  always @(negedge clk) begin
    logic [32:0] exp;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_result: got 0x%0h, expected no result", bus.out_product);
      end else begin
        exp = sb.pop_front();
        checkOutput("out_product", bus.out_product, exp[31:0]);
        checkOutput("out_err", 32'(bus.out_err), 32'(exp[32]));
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] m, input logic [15:0] q,
                               input logic [31:0] exp_p, input logic exp_e, input bit expect_out);
    int n;
    n = 0;
    if (expect_out) sb.push_back({exp_e, exp_p});
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_m     = m;
    bus.in_q     = q;
    @(negedge clk);
    while (!bus.in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) boundFail("in_ready_wait");
    @(posedge clk); #1;
    last_accept  = cyc;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("core_start_high", 32'(bus.core_start), 32'd1);
    checkOutput("core_m", 32'(bus.core_m), 32'(m));
    checkOutput("core_q", 32'(bus.core_q), 32'(q));
    @(negedge clk);
    checkOutput("core_start_low", 32'(bus.core_start), 32'd0);
  endtask

  task automatic waitValid(output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) boundFail("out_valid_wait");
    lat = cyc - last_accept;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    @(negedge clk);
    while (!(sb.size() == 0 && bus.in_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!(sb.size() == 0 && bus.in_ready)) boundFail("drain_wait");
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
`ifdef BOOTH_SEQ_TIMEOUT_EN
    localparam int HANG_CYCLES = 40;
`else
    localparam int HANG_CYCLES = 150;
`endif
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_m      = '0;
    bus.in_q      = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_core_start", 32'(bus.core_start), 32'd0);
    checkOutput("rst_out_err", 32'(bus.out_err), 32'd0);
    checkOutput("rst_out_product", bus.out_product, 32'd0);
    checkOutput("rst_core_m", 32'(bus.core_m), 32'd0);
    checkOutput("rst_core_q", 32'(bus.core_q), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    $display("[TB] basic and signed products");
    core_lat = 40;
    applyStimulus(16'd3, 16'd5, 32'h0000_000F, 1'b0, 1'b1);
    waitValid(lat);
    checkOutput("basic_latency", 32'(lat), 32'd42);
    waitDrain();
    applyStimulus(16'hFFFE, 16'd7, 32'hFFFF_FFF2, 1'b0, 1'b1);
    waitDrain();
    applyStimulus(16'h8000, 16'h8000, 32'h4000_0000, 1'b0, 1'b1);
    waitDrain();
    applyStimulus(16'h7FFF, 16'hFFFF, 32'hFFFF_8001, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] back-pressure with a pending pair");
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    applyStimulus(16'h0010, 16'h0011, 32'h0000_0110, 1'b0, 1'b1);
    waitValid(lat);
    fork
      applyStimulus(16'hFFFF, 16'hFFFF, 32'h0000_0001, 1'b0, 1'b1);
      begin
        repeat (10) begin
          @(negedge clk);
          checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
          checkOutput("bp_out_product", bus.out_product, 32'h0000_0110);
          checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
          checkOutput("bp_core_start", 32'(bus.core_start), 32'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    waitDrain();

    $display("[TB] stale done through blanking");
    stale_mode = 1'b1;
    core_lat   = 10;
    applyStimulus(16'd2, 16'd9, 32'h0000_0012, 1'b0, 1'b1);
    waitDrain();
    stale_mode = 1'b0;
    core_lat   = 40;

`ifdef BOOTH_SEQ_TIMEOUT_EN
    $display("[TB] timeout abort");
    core_hang = 1'b1;
    applyStimulus(16'd4, 16'd4, 32'h0000_0000, 1'b1, 1'b1);
    waitValid(lat);
    checkOutput("timeout_latency", 32'(lat), 32'd67);
    waitDrain();
`endif

    $display("[TB] hung core then reset mid-WAIT");
    core_hang = 1'b1;
    applyStimulus(16'd6, 16'd6, 32'h0, 1'b0, 1'b0);
    repeat (HANG_CYCLES) @(negedge clk);
    checkOutput("hang_busy", 32'(busy), 32'd1);
    checkOutput("hang_no_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_core_start", 32'(bus.core_start), 32'd0);
    checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("midrst_core_m", 32'(bus.core_m), 32'd0);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    core_hang = 1'b0;
    @(negedge clk);
    checkOutput("in_ready_after_midrst", 32'(bus.in_ready), 32'd1);
    applyStimulus(16'd3, 16'd5, 32'h0000_000F, 1'b0, 1'b1);
    waitDrain();

    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
